controlador_display_multiplexado: RTL



---
 rtl/controlador_display_multiplexado_pkg.sv | 17 +
 rtl/controlador_display_multiplexado_7seg.sv | 28 ++
 rtl/controlador_display_multiplexado.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/controlador_display_multiplexado_pkg.sv
// Shared constants, handshake state type and counter width helper for the
// multiplexed 7-segment display controller.
package pkg_display;

  localparam logic [6:0] SEG_APAGADO = 7'h7F;

  typedef enum logic {
    LIBRE,
    PENDIENTE
  } estado_carga_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int ancho_contador(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/controlador_display_multiplexado_7seg.sv
// Hex nibble to 7-segment decoder; output is active-low, bit order {g..a}.
module modulo_7segmentos (
  input  logic [3:0] data,
  output logic [6:0] display
);

  always_comb begin
    unique case (data)
      4'h0: display = 7'h40;
      4'h1: display = 7'h79;
      4'h2: display = 7'h24;
      4'h3: display = 7'h30;
      4'h4: display = 7'h19;
      4'h5: display = 7'h12;
      4'h6: display = 7'h02;
      4'h7: display = 7'h78;
      4'h8: display = 7'h00;
      4'h9: display = 7'h10;
      4'hA: display = 7'h08;
      4'hB: display = 7'h03;
      4'hC: display = 7'h46;
      4'hD: display = 7'h21;
      4'hE: display = 7'h06;
      default: display = 7'h0E;
    endcase
  end

endmodule

// File: rtl/controlador_display_multiplexado.sv
// Time-multiplexed N_DIG-digit hex display with frame-atomic valid/ready load.
// Optional anti-ghosting dead time per slot: define CONTROLADOR_DISPLAY_BLANCO_EN.
module controlador_display_multiplexado
  import pkg_display::*;
#(
  parameter int N_DIG         = 4,
  parameter int CICLOS_DIGITO = 100000,
  parameter int CICLOS_BLANCO = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*N_DIG-1:0]   valor_in,
  input  logic [N_DIG-1:0]     mascara_in,
  input  logic                 cargar,
  output logic                 listo,
  output logic [6:0]           segmentos,
  output logic [N_DIG-1:0]     anodos,
  output logic                 fin_trama
);

  localparam int CNT_W = ancho_contador(CICLOS_DIGITO);
  localparam int IDX_W = ancho_contador(N_DIG);

  if (N_DIG < 2 || N_DIG > 8 || CICLOS_DIGITO < 2 || CICLOS_BLANCO >= CICLOS_DIGITO)
  begin : g_param_invalido
    $error("controlador_display_multiplexado: invalid parameter set");
  end

  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic               tick;
  logic               frontera;

  estado_carga_t      estado, estado_sig;
  logic               captura, commit;

  logic [4*N_DIG-1:0] pend_val, act_val;
  logic [N_DIG-1:0]   pend_mask, act_mask;

  logic [3:0]         nibble_sel;
  logic               digito_on;
  logic [N_DIG-1:0]   sel_onehot;
  logic [6:0]         seg_dec;
  logic               en_blanco;

  assign tick     = (cnt == CNT_W'(CICLOS_DIGITO - 1));
  assign frontera = tick && (idx == IDX_W'(N_DIG - 1));

  // NOTE: sequential state is updated with <= so every register samples the
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(N_DIG - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) estado <= LIBRE;
    else     estado <= estado_sig;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    estado_sig = estado;
    listo      = 1'b0;
    captura    = 1'b0;
    commit     = 1'b0;
    unique case (estado)
      LIBRE: begin
        listo = 1'b1;
        if (cargar) begin
          captura    = 1'b1;
          estado_sig = PENDIENTE;
        end
      end
      PENDIENTE: begin
        if (frontera) begin
          commit     = 1'b1;
          estado_sig = LIBRE;
        end
      end
      default: estado_sig = LIBRE;
    endcase
  end

  // NOTE: the frame buffers are plain registers, not a memory, so they are
  // reset; that is what drops a pending frame on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val  <= '0;
      pend_mask <= '0;
      act_val   <= '0;
      act_mask  <= '0;
    end else begin
      if (captura) begin
        pend_val  <= valor_in;
        pend_mask <= mascara_in;
      end
      if (commit) begin
        act_val  <= pend_val;
        act_mask <= pend_mask;
      end
    end
  end

  always_comb begin
    nibble_sel = '0;
    digito_on  = 1'b0;
    sel_onehot = '0;
    for (int k = 0; k < N_DIG; k++) begin
      if (idx == IDX_W'(k)) begin
        nibble_sel    = act_val[4*k +: 4];
        digito_on     = act_mask[k];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  modulo_7segmentos u_decoder (
    .data    (nibble_sel),
    .display (seg_dec)
  );

`ifdef CONTROLADOR_DISPLAY_BLANCO_EN
  assign en_blanco = (cnt < CNT_W'(CICLOS_BLANCO));
`else
  assign en_blanco = 1'b0;
`endif

  // Outputs are registered so the display pins never glitch on idx changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      anodos    <= '1;
      segmentos <= SEG_APAGADO;
      fin_trama <= 1'b0;
    end else begin
      fin_trama <= frontera;
      if (digito_on && !en_blanco) begin
        anodos    <= ~sel_onehot;
        segmentos <= seg_dec;
      end else begin
        anodos    <= '1;
        segmentos <= SEG_APAGADO;
      end
    end
  end

endmodule
